sram_arbiter: RTL and testbench

Time-multiplexes the single external 8-bit async SRAM between the video fetch port (read-only) and the CPU port (read/write), so the rest of the design sees two independent ports. Sits between the memory-mapping logic, which supplies the CPU-side 19-bit address, and the SRAM pins. It runs in the fast memory clock domain and owns every SRAM strobe.

---
 rtl/sram_arb_pkg.sv | 32 +++
 rtl/sram_arbiter.sv | 175 +++++++++++++++++
 tb/tb_sram_arbiter.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM arbiter: bus widths, FSM encoding, grant ids
// and the debug view that exposes the arbiter's internal state.
package sram_arb_pkg;
    localparam int SRAM_AW = 19;
    localparam int SRAM_DW = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        V_ADDR   = 3'd1,
        V_SAMP   = 3'd2,
        C_ADDR   = 3'd3,
        C_SAMP   = 3'd4,
        W_SETUP  = 3'd5,
        W_STROBE = 3'd6,
        W_HOLD   = 3'd7
    } arb_state_e;

    localparam logic GRANT_VIDEO = 1'b0;
    localparam logic GRANT_CPU   = 1'b1;

    typedef struct packed {
        arb_state_e state;
        logic       data_oe;
        logic       v_pend;
        logic       c_pend;
        logic       last_grant;
    } arb_dbg_t;

    function automatic logic is_write_state(input arb_state_e s);
        return (s == W_SETUP) || (s == W_STROBE) || (s == W_HOLD);
    endfunction
endpackage

// File: rtl/sram_arbiter.sv
// Shares one async 8-bit SRAM between a read-only video port and a read/write
// CPU port. IDLE is visited between every access; ties alternate between ports.
module sram_arbiter
    import sram_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vreq,
    input  logic [SRAM_AW-1:0] vaddr,
    output logic [SRAM_DW-1:0] vdout,
    output logic               vvalid,
    output logic               v_overrun,
    input  logic               crd,
    input  logic               cwr,
    input  logic [SRAM_AW-1:0] caddr,
    input  logic [SRAM_DW-1:0] cdin,
    output logic [SRAM_DW-1:0] cdout,
    output logic               cack,
    output logic [SRAM_AW-1:0] sram_addr,
    inout  wire  [SRAM_DW-1:0] sram_data,
    output logic               sram_we_n,
    output arb_dbg_t           dbg
);
    arb_state_e         state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic               v_pend_q, v_pend_d;
    logic [SRAM_AW-1:0] v_addr_q, v_addr_d;
    logic               v_overrun_q, v_overrun_d;
    logic               crd_q, cwr_q;
    logic               c_done_q, c_done_d;
    logic               c_pend;
    logic [SRAM_DW-1:0] vdout_q, vdout_d;
    logic               vvalid_q, vvalid_d;
    logic [SRAM_DW-1:0] cdout_q, cdout_d;
    logic               cack_q, cack_d;
    logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
    logic               we_n_q, we_n_d;
    logic               data_oe_q, data_oe_d;

    // CPU request is registered so a request seen at edge N is granted at N+1.
    assign c_pend = (crd_q | cwr_q) & ~c_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_CPU;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (v_pend_q && c_pend) begin
                    if (last_grant_q == GRANT_CPU) begin
                        state_d      = V_ADDR;
                        last_grant_d = GRANT_VIDEO;
                    end else begin
                        state_d      = cwr_q ? W_SETUP : C_ADDR;
                        last_grant_d = GRANT_CPU;
                    end
                end else if (v_pend_q) begin
                    state_d = V_ADDR;
                end else if (c_pend) begin
                    state_d = cwr_q ? W_SETUP : C_ADDR;
                end
            end
            V_ADDR:   state_d = V_SAMP;
            V_SAMP:   state_d = IDLE;
            C_ADDR:   state_d = C_SAMP;
            C_SAMP:   state_d = IDLE;
            W_SETUP:  state_d = W_STROBE;
            W_STROBE: state_d = W_HOLD;
            W_HOLD:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Pin controls are decoded from the next state so they leave flops cleanly.
    always_comb begin
        we_n_d      = (state_d != W_STROBE);
        data_oe_d   = is_write_state(state_d);
        sram_addr_d = sram_addr_q;
        case (state_d)
            V_ADDR, V_SAMP:                    sram_addr_d = v_addr_d;
            C_ADDR, C_SAMP, W_SETUP, W_STROBE,
            W_HOLD:                            sram_addr_d = caddr;
            default:                           sram_addr_d = sram_addr_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_n_q      <= 1'b1;
            data_oe_q   <= 1'b0;
            sram_addr_q <= '0;
        end else begin
            we_n_q      <= we_n_d;
            data_oe_q   <= data_oe_d;
            sram_addr_q <= sram_addr_d;
        end
    end

    always_comb begin
        v_addr_d    = vreq ? vaddr : v_addr_q;
        v_overrun_d = v_overrun_q | (vreq & v_pend_q);
        if (vreq) begin
            v_pend_d = 1'b1;
        end else if (state_q == V_SAMP) begin
            v_pend_d = 1'b0;
        end else begin
            v_pend_d = v_pend_q;
        end
        vvalid_d = (state_q == V_SAMP);
        vdout_d  = (state_q == V_SAMP) ? sram_data : vdout_q;
        cack_d   = (state_q == C_SAMP) || (state_q == W_HOLD);
        cdout_d  = (state_q == C_SAMP) ? sram_data : cdout_q;
        // A held request is served once; the CPU must drop both strobes to re-arm.
        if (cack_d) begin
            c_done_d = 1'b1;
        end else if (!crd && !cwr) begin
            c_done_d = 1'b0;
        end else begin
            c_done_d = c_done_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_pend_q    <= 1'b0;
            v_addr_q    <= '0;
            v_overrun_q <= 1'b0;
            crd_q       <= 1'b0;
            cwr_q       <= 1'b0;
            c_done_q    <= 1'b0;
            vdout_q     <= '0;
            vvalid_q    <= 1'b0;
            cdout_q     <= '0;
            cack_q      <= 1'b0;
        end else begin
            v_pend_q    <= v_pend_d;
            v_addr_q    <= v_addr_d;
            v_overrun_q <= v_overrun_d;
            crd_q       <= crd;
            cwr_q       <= cwr;
            c_done_q    <= c_done_d;
            vdout_q     <= vdout_d;
            vvalid_q    <= vvalid_d;
            cdout_q     <= cdout_d;
            cack_q      <= cack_d;
        end
    end

    assign sram_data = data_oe_q ? cdin : {SRAM_DW{1'bz}};
    assign sram_addr = sram_addr_q;
    assign sram_we_n = we_n_q;
    assign vdout     = vdout_q;
    assign vvalid    = vvalid_q;
    assign v_overrun = v_overrun_q;
    assign cdout     = cdout_q;
    assign cack      = cack_q;

    always_comb begin
        dbg            = '0;
        dbg.state      = state_q;
        dbg.data_oe    = data_oe_q;
        dbg.v_pend     = v_pend_q;
        dbg.c_pend     = c_pend;
        dbg.last_grant = last_grant_q;
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural async SRAM, scoreboard queues for the video
// and CPU ports, directed timing/arbitration cases and a short random mix.
module tb_sram_arbiter;
    import sram_arb_pkg::*;

    logic               clk   = 1'b0;
    logic               rst_n = 1'b0;
    logic               vreq  = 1'b0;
    logic [SRAM_AW-1:0] vaddr = '0;
    logic               crd   = 1'b0;
    logic               cwr   = 1'b0;
    logic [SRAM_AW-1:0] caddr = '0;
    logic [SRAM_DW-1:0] cdin  = '0;
    logic [SRAM_DW-1:0] vdout, cdout;
    logic               vvalid, v_overrun, cack, sram_we_n;
    logic [SRAM_AW-1:0] sram_addr;
    wire  [SRAM_DW-1:0] sram_data;
    arb_dbg_t           dbg;

    sram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .vreq(vreq), .vaddr(vaddr), .vdout(vdout), .vvalid(vvalid), .v_overrun(v_overrun),
        .crd(crd), .cwr(cwr), .caddr(caddr), .cdin(cdin), .cdout(cdout), .cack(cack),
        .sram_addr(sram_addr), .sram_data(sram_data), .sram_we_n(sram_we_n), .dbg(dbg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Unwritten SRAM locations read back as a fixed address hash (19'h2A000 -> 8'h5C).
    function automatic logic [7:0] pat(input logic [18:0] a);
        return a[7:0] ^ a[15:8] ^ {5'b0, a[18:16]} ^ 8'hFE;
    endfunction

    logic [7:0] mem [logic [18:0]];
    logic [7:0] mdl_rd = 8'h00;
    logic       mdl_oe;
    assign mdl_oe    = dbg.state inside {V_ADDR, V_SAMP, C_ADDR, C_SAMP};
    assign sram_data = mdl_oe ? mdl_rd : 8'hzz;

    always @(negedge clk) begin
        if (!sram_we_n) mem[sram_addr] = sram_data;
        mdl_rd = mem.exists(sram_addr) ? mem[sram_addr] : pat(sram_addr);
    end

    logic [7:0] shadow [logic [18:0]];
    function automatic logic [7:0] exp_mem(input logic [18:0] a);
        return shadow.exists(a) ? shadow[a] : pat(a);
    endfunction

    logic [7:0] v_exp_q[$];
    int         v_due_q[$];
    logic [8:0] c_exp_q[$];
    int         c_due_q[$];
    logic [7:0] last_rd = 8'h00;

    int we_lo_cnt = 0;
    int we_lo_cyc = -1;
    int w_cycles  = 0;
    int w_bad     = 0;
    int oe_bad    = 0;

    always @(negedge clk) begin
        logic [7:0] e8;
        logic [8:0] e9;
        int         due;
        if (!sram_we_n) begin
            we_lo_cnt++;
            we_lo_cyc = cyc;
        end
        if (is_write_state(dbg.state)) begin
            w_cycles++;
            if (sram_addr !== caddr || sram_data !== cdin) w_bad++;
        end
        if (is_write_state(dbg.state) != dbg.data_oe) oe_bad++;
        if (vvalid) begin
            if (v_exp_q.size() == 0) begin
                check("v_unexpected", 32'(vvalid), 32'(0));
            end else begin
                e8  = v_exp_q.pop_front();
                due = v_due_q.pop_front();
                check("vdout", 32'(vdout), 32'(e8));
                if (due >= 0) check("v_latency", cyc, due);
            end
        end
        if (cack) begin
            if (c_exp_q.size() == 0) begin
                check("c_unexpected", 32'(cack), 32'(0));
            end else begin
                e9  = c_exp_q.pop_front();
                due = c_due_q.pop_front();
                if (e9[8]) begin
                    check("cdout_rd", 32'(cdout), 32'(e9[7:0]));
                    last_rd = e9[7:0];
                end else begin
                    check("cdout_hold", 32'(cdout), 32'(last_rd));
                end
                if (due >= 0) check("c_latency", cyc, due);
            end
        end
    end

    // Drives video and/or CPU requests sampled at the same edge n_edge; offsets < 0 mean untimed.
    task automatic issue(input bit do_v, input logic [18:0] va, input int v_off,
                         input bit do_c, input bit wr, input logic [18:0] ca,
                         input logic [7:0] cd, input int c_off, output int n_edge);
        @(posedge clk);
        #1;
        n_edge = cyc + 1;
        if (do_v) begin
            vreq  = 1'b1;
            vaddr = va;
            v_exp_q.push_back(exp_mem(va));
            v_due_q.push_back(v_off < 0 ? -1 : n_edge + v_off);
        end
        if (do_c) begin
            crd   = !wr;
            cwr   = wr;
            caddr = ca;
            cdin  = cd;
            if (wr) begin
                shadow[ca] = cd;
                c_exp_q.push_back({1'b0, cd});
            end else begin
                c_exp_q.push_back({1'b1, exp_mem(ca)});
            end
            c_due_q.push_back(c_off < 0 ? -1 : n_edge + c_off);
        end
        @(posedge clk);
        #1;
        vreq = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((v_exp_q.size() + c_exp_q.size()) != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check(tag, v_exp_q.size() + c_exp_q.size(), 0);
        v_exp_q.delete();
        v_due_q.delete();
        c_exp_q.delete();
        c_due_q.delete();
        @(posedge clk);
        #1;
        crd = 1'b0;
        cwr = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int         n, quiet, we0, wc0, wb0, acks, op;
        logic [18:0] a;
        logic [7:0]  d;

        repeat (3) @(posedge clk);
        #1;
        check("rst_state", 32'(dbg.state), 32'(IDLE));
        check("rst_we_n", 32'(sram_we_n), 1);
        check("rst_oe", 32'(dbg.data_oe), 0);
        check("rst_addr", 32'(sram_addr), 0);
        check("rst_vdout", 32'(vdout), 0);
        check("rst_cdout", 32'(cdout), 0);
        check("rst_vvalid", 32'(vvalid), 0);
        check("rst_cack", 32'(cack), 0);
        check("rst_overrun", 32'(v_overrun), 0);
        rst_n = 1'b1;

        quiet = 0;
        repeat (10) begin
            @(negedge clk);
            if (sram_we_n !== 1'b1 || dbg.data_oe || vvalid || cack) quiet++;
        end
        check("idle_quiet", quiet, 0);

        // First tie after reset: video, then CPU. Second tie: CPU first.
        issue(1'b1, 19'h00040, 3, 1'b1, 1'b0, 19'h01234, 8'h00, 6, n);
        wait_drain("tie1_drain");
        issue(1'b1, 19'h00080, 6, 1'b1, 1'b0, 19'h02345, 8'h00, 3, n);
        wait_drain("tie2_drain");

        we0 = we_lo_cnt;
        issue(1'b1, 19'h2A000, 3, 1'b0, 1'b0, 19'h0, 8'h00, -1, n);
        wait_drain("vid_drain");
        check("vid_no_we", we_lo_cnt - we0, 0);

        we0 = we_lo_cnt;
        wc0 = w_cycles;
        wb0 = w_bad;
        issue(1'b0, 19'h0, -1, 1'b1, 1'b1, 19'h14000, 8'hA5, 4, n);
        repeat (20) @(posedge clk);
        wait_drain("wr_drain");
        check("wr_we_pulses", we_lo_cnt - we0, 1);
        check("wr_we_cycle", we_lo_cyc, n + 2);
        check("wr_states", w_cycles - wc0, 3);
        check("wr_bus_stable", w_bad - wb0, 0);

        issue(1'b0, 19'h0, -1, 1'b1, 1'b0, 19'h14000, 8'h00, 3, n);
        wait_drain("rdback_drain");
        check("rdback_cdout", 32'(cdout), 32'(8'hA5));

        check("ovr_clear", 32'(v_overrun), 0);
        @(posedge clk);
        #1;
        vreq  = 1'b1;
        vaddr = 19'h00100;
        @(posedge clk);
        #1;
        vaddr = 19'h00200;
        v_exp_q.push_back(exp_mem(19'h00200));
        v_due_q.push_back(cyc + 3);
        @(posedge clk);
        #1;
        vreq = 1'b0;
        wait_drain("ovr_drain");
        check("ovr_set", 32'(v_overrun), 1);

        for (int i = 0; i < 16; i++) begin
            op = $urandom_range(0, 3);
            a  = 19'($urandom_range(0, 7)) << 12;
            d  = 8'($urandom_range(0, 255));
            case (op)
                0:       issue(1'b1, a, -1, 1'b0, 1'b0, 19'h0, 8'h00, -1, n);
                1:       issue(1'b0, 19'h0, -1, 1'b1, 1'b0, a, 8'h00, -1, n);
                2:       issue(1'b0, 19'h0, -1, 1'b1, 1'b1, a, d, -1, n);
                default: issue(1'b1, a, -1, 1'b1, 1'b0, a ^ 19'h00800, 8'h00, -1, n);
            endcase
            wait_drain("rnd_drain");
        end

        // Reset in the middle of a write strobe: pins release at once, no ack.
        @(posedge clk);
        #1;
        cwr   = 1'b1;
        caddr = 19'h30000;
        cdin  = 8'h77;
        n = 0;
        while (dbg.state != W_STROBE && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("rst_reach_strobe", 32'(dbg.state), 32'(W_STROBE));
        check("rst_we_low", 32'(sram_we_n), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_we_async", 32'(sram_we_n), 1);
        check("rst_bus_async", 32'(dbg.data_oe), 0);
        check("rst_state_async", 32'(dbg.state), 32'(IDLE));
        cwr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (cack) acks++;
        end
        check("rst_no_ack", acks, 0);
        check("rst_idle_after", 32'(dbg.state), 32'(IDLE));
        check("oe_consistent", oe_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
